// File: rtl/game_speed_ticker.sv
// game_speed_ticker: turns a requested difficulty level into a periodic
// one-cycle Tick, reports the level in force and optionally ramps it up.
//
// state   | meaning
// S_RUN   | period counter advancing, boundaries produce ticks
// S_PAUSE | counter, ramp counter and GameSpeed frozen
module game_speed_ticker #(
    parameter int NUM_LEVELS  = 4,
    parameter int LVL_W       = 2,
    parameter int CNT_W       = 26,
    parameter int BASE_PERIOD = 50_000_000,
    parameter int STEP_SHIFT  = 1,
    parameter int MIN_PERIOD  = 1000,
    parameter int RAMP_TICKS  = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [LVL_W-1:0] Level,
    input  logic             AutoMode,
    input  logic             Pause,
    output logic             Tick,
    output logic [LVL_W-1:0] GameSpeed,
    output logic             LevelChanged
);

    localparam int RAMP_W = $clog2(RAMP_TICKS + 1);
    localparam logic [RAMP_W-1:0] RAMP_MAX = RAMP_W'(RAMP_TICKS - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0]  BASE_C   = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(MIN_PERIOD);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_PAUSE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RAMP_W-1:0]  ramp_q, ramp_d;
    logic [LVL_W-1:0]   speed_q, speed_d;
    logic               tick_q, tick_d;
    logic               changed_q, changed_d;

    logic [LVL_W-1:0]   lvl_req;
    logic [LVL_W-1:0]   lvl_next;
    logic [LVL_W-1:0]   speed_inc;
    logic [CNT_W-1:0]   period_m1;
    logic               boundary;

    function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] lvl);
        if (int'(lvl) > NUM_LEVELS - 1) begin
            return LVL_MAX;
        end
        return lvl;
    endfunction

    // Shift is done at full counter width, then floored at MIN_PERIOD.
    function automatic logic [CNT_W-1:0] period_of(input logic [LVL_W-1:0] lvl);
        logic [CNT_W-1:0] shifted;
        shifted = BASE_C >> (int'(lvl) * STEP_SHIFT);
        return (shifted < MIN_C) ? MIN_C : shifted;
    endfunction

    // Boundary detection and next-level selection.
    always_comb begin
        lvl_req   = clamp_lvl(Level);
        period_m1 = period_of(speed_q) - CNT_W'(1);
        boundary  = (cnt_q == period_m1);
        speed_inc = (speed_q == LVL_MAX) ? LVL_MAX : speed_q + LVL_W'(1);
        lvl_next  = speed_q;
        if (!AutoMode) begin
            lvl_next = lvl_req;
        end else if (lvl_req > speed_q) begin
            lvl_next = lvl_req;
        end else if (ramp_q == RAMP_MAX) begin
            lvl_next = speed_inc;
        end
    end

    // Pause FSM plus counter, ramp and output updates. The release cycle itself
    // advances the counter, so a pause stretches the interval by exactly its length.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ramp_d    = ramp_q;
        speed_d   = speed_q;
        tick_d    = 1'b0;
        changed_d = 1'b0;

        case (state_q)
            S_RUN:   if (Pause)  state_d = S_PAUSE;
            S_PAUSE: if (!Pause) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        if (state_d == S_RUN) begin
            if (boundary) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                speed_d = lvl_next;
                if (lvl_next != speed_q) begin
                    changed_d = 1'b1;
                    ramp_d    = '0;
                end else if (ramp_q != RAMP_MAX) begin
                    ramp_d = ramp_q + RAMP_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            ramp_q    <= '0;
            speed_q   <= '0;
            tick_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ramp_q    <= ramp_d;
            speed_q   <= speed_d;
            tick_q    <= tick_d;
            changed_q <= changed_d;
        end
    end

    assign Tick         = tick_q;
    assign GameSpeed    = speed_q;
    assign LevelChanged = changed_q;

endmodule

// File: tb/tb_game_speed_ticker.sv
// Bench for game_speed_ticker: directed phases plus random traffic, with a
// tick-time reference model feeding a scoreboard queue.
module tb_game_speed_ticker;

    localparam int NUM_LEVELS  = 4;
    localparam int LVL_W       = 2;
    localparam int CNT_W       = 5;
    localparam int BASE_PERIOD = 16;
    localparam int STEP_SHIFT  = 1;
    localparam int MIN_PERIOD  = 3;
    localparam int RAMP_TICKS  = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic [LVL_W-1:0] Level = '0;
    logic             AutoMode = 1'b0;
    logic             Pause = 1'b0;
    logic             Tick;
    logic [LVL_W-1:0] GameSpeed;
    logic             LevelChanged;

    game_speed_ticker #(
        .NUM_LEVELS (NUM_LEVELS),
        .LVL_W      (LVL_W),
        .CNT_W      (CNT_W),
        .BASE_PERIOD(BASE_PERIOD),
        .STEP_SHIFT (STEP_SHIFT),
        .MIN_PERIOD (MIN_PERIOD),
        .RAMP_TICKS (RAMP_TICKS)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Level       (Level),
        .AutoMode    (AutoMode),
        .Pause       (Pause),
        .Tick        (Tick),
        .GameSpeed   (GameSpeed),
        .LevelChanged(LevelChanged)
    );

    always #5 Clock = ~Clock;

    int edge_n = 0;
    always @(posedge Clock) edge_n <= edge_n + 1;

    typedef struct {
        int cyc;
        int gs;
        int lc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;

    // Reference model: absolute edge at which the next tick is due.
    int m_gs   = 0;
    int m_ramp = 0;
    int m_due  = 0;

    function automatic int period(input int l);
        int p;
        p = BASE_PERIOD >> (l * STEP_SHIFT);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Predicts what the upcoming edge n does with the inputs now being driven.
    task automatic model_edge(input int n);
        int cl;
        int nl;
        exp_t e;
        if (Reset) begin
            m_gs   = 0;
            m_ramp = 0;
            m_due  = n + BASE_PERIOD;
            return;
        end
        if (Pause) begin
            m_due++;
            return;
        end
        if (n != m_due) return;
        cl = (int'(Level) > NUM_LEVELS - 1) ? NUM_LEVELS - 1 : int'(Level);
        if (!AutoMode)                 nl = cl;
        else if (cl > m_gs)            nl = cl;
        else if (m_ramp == RAMP_TICKS - 1)
            nl = (m_gs + 1 > NUM_LEVELS - 1) ? NUM_LEVELS - 1 : m_gs + 1;
        else                           nl = m_gs;
        e.cyc = n;
        e.gs  = nl;
        e.lc  = (nl != m_gs) ? 1 : 0;
        sb_q.push_back(e);
        if (nl != m_gs)                  m_ramp = 0;
        else if (m_ramp < RAMP_TICKS - 1) m_ramp++;
        m_gs  = nl;
        m_due = n + period(nl);
    endtask

    task automatic step();
        model_edge(edge_n + 1);
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tick"}, int'(Tick), 0);
        chk({tag, "_speed"}, int'(GameSpeed), 0);
        chk({tag, "_changed"}, int'(LevelChanged), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a tick.
    always @(negedge Clock) begin
        if (started) begin
            n_checks++;
            if (LevelChanged === 1'b1 && Tick !== 1'b1) begin
                n_fail++;
                $display("FAIL changed_without_tick: LevelChanged=%b Tick=%b (edge %0d)",
                         LevelChanged, Tick, edge_n);
            end
            if (Tick === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tick: tick at edge %0d, none expected", edge_n);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("tick_cycle", edge_n, e.cyc);
                    chk("tick_speed", int'(GameSpeed), e.gs);
                    chk("tick_changed", int'(LevelChanged), e.lc);
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= edge_n) begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_tick: no tick at edge %0d, expected at %0d", edge_n, e.cyc);
            end
        end
    end

    initial begin
        @(negedge Clock);

        // Reset and base rate.
        Reset = 1'b1;
        run(3);
        started = 1'b1;
        chk_reset_outputs("reset");
        Reset = 1'b0;
        run(50);

        // Level change requested mid-interval, taken at the boundary.
        Reset = 1'b1;
        run(2);
        chk_reset_outputs("reset2");
        Reset = 1'b0;
        run(4);
        Level = 2'd2;
        run(30);

        // Top level hits the minimum-period floor.
        Level = 2'd3;
        run(20);

        // Pause for 10 cycles starting at cycle 12.
        Reset = 1'b1;
        Level = 2'd0;
        run(1);
        Reset = 1'b0;
        run(11);
        Pause = 1'b1;
        run(10);
        Pause = 1'b0;
        run(20);

        // Pause held across the boundary cycle.
        Reset = 1'b1;
        run(1);
        Reset = 1'b0;
        run(15);
        Pause = 1'b1;
        run(3);
        Pause = 1'b0;
        run(10);

        // Auto-ramp to the top, then a lower request has no effect.
        Reset = 1'b1;
        AutoMode = 1'b1;
        Level = 2'd0;
        run(1);
        Reset = 1'b0;
        run(150);
        chk("auto_top_speed", int'(GameSpeed), NUM_LEVELS - 1);
        Level = 2'd1;
        run(20);
        chk("auto_floor_ignored", int'(GameSpeed), NUM_LEVELS - 1);

        // Raised request mid-ramp jumps straight to it.
        Reset = 1'b1;
        Level = 2'd0;
        run(1);
        Reset = 1'b0;
        run(40);
        Level = 2'd3;
        run(30);

        // Reset in the middle of operation at the top level.
        Reset = 1'b1;
        run(1);
        chk_reset_outputs("reset_mid");
        Reset = 1'b0;
        AutoMode = 1'b0;
        Level = 2'd0;
        run(20);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 299) == 0);
            Pause = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0)  Level = LVL_W'($urandom_range(0, NUM_LEVELS - 1));
            if ($urandom_range(0, 99) == 0)  AutoMode = ~AutoMode;
            step();
        end
        Reset = 1'b0;
        Pause = 1'b0;

        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
